// File: rtl/sar_pkg.sv
// Shared constants for the SAR conversion controller: code/counter widths,
// FSM state encodings and the trial-bit mask helper.
package sar_pkg;

    localparam int CODE_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // One-hot mask selecting the trial bit idx of the DAC code.
    function automatic logic [CODE_W-1:0] bit_mask(input logic [2:0] idx);
        return {{(CODE_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sar_timer.sv
// Loadable down-counter with terminal-count flags, shared by the sample and
// settle intervals of the SAR controller.
module sar_timer
    import sar_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o,
    output logic             tc_next_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != CNT_ZERO) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    // tc_next lets the controller register a strobe for the final count cycle.
    assign tc_o      = (count_q == CNT_ZERO);
    assign tc_next_o = (count_d == CNT_ZERO);

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: samples the input, then resolves
// an 8-bit code MSB first using a clocked comparator, one bit per settle interval.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              comp,
    output logic              sample,
    output logic              latch_en,
    output logic [CODE_W-1:0] dac_p,
    output logic [CODE_W-1:0] dac_n,
    output logic [CODE_W-1:0] result,
    output logic              busy,
    output logic              valid
);

    localparam logic [CNT_W-1:0]  SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_ZERO   = {CODE_W{1'b0}};

    logic [1:0]        state_q,  state_d;
    logic [2:0]        bit_q,    bit_d;
    logic [CODE_W-1:0] dac_q,    dac_d;
    logic [CODE_W-1:0] result_q, result_d;
    logic              sample_q, sample_d;
    logic              latch_q,  latch_d;
    logic              busy_q,   busy_d;
    logic              valid_q,  valid_d;
    logic [CODE_W-1:0] decided_s;
    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              tmr_tc_s;
    logic              tmr_tc_next_s;

    sar_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .tc_o       (tmr_tc_s),
        .tc_next_o  (tmr_tc_next_s)
    );

    // dac_q already carries the trial bit set; comp=0 clears it.
    assign decided_s = comp ? dac_q : (dac_q & ~bit_mask(bit_q));

    // Next-state and output decode; all outputs are precomputed for registering.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        dac_d      = dac_q;
        result_d   = result_q;
        sample_d   = sample_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = SETTLE_LOAD;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                dac_d = CODE_ZERO;
                if (start) begin
                    state_d    = ST_SAMPLE;
                    sample_d   = 1'b1;
                    busy_d     = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SAMPLE_LOAD;
                end else begin
                    state_d  = ST_IDLE;
                    sample_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (tmr_tc_s) begin
                    state_d    = ST_CONV;
                    sample_d   = 1'b0;
                    bit_d      = 3'd7;
                    dac_d      = bit_mask(3'd7);
                    tmr_load_s = 1'b1;
                end else begin
                    sample_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (!tmr_tc_s) begin
                    dac_d = dac_q;
                end else if (bit_q == 3'd0) begin
                    state_d  = ST_DONE;
                    result_d = decided_s;
                    dac_d    = CODE_ZERO;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    bit_d      = bit_q - 3'd1;
                    dac_d      = decided_s | bit_mask(bit_q - 3'd1);
                    tmr_load_s = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                dac_d    = CODE_ZERO;
                sample_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
        latch_d = (state_d == ST_CONV) && tmr_tc_next_s;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bit_q    <= 3'd0;
            dac_q    <= CODE_ZERO;
            result_q <= CODE_ZERO;
            sample_q <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            sample_q <= sample_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign sample   = sample_q;
    assign latch_en = latch_q;
    assign dac_p    = dac_q;
    assign dac_n    = ~dac_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Scoreboard bench for sar_ctrl: default timing instance plus a 3/2 timing
// instance, each driven by an ideal comparator model comp = (vin >= dac_p).
module tb_sar_ctrl;

    typedef struct packed {
        logic [7:0]  res;
        logic [31:0] due;
        logic        chk;
        logic [63:0] trials;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] vin0, vin1;
    logic       comp0, comp1;
    logic       sample0, latch0, busy0, valid0;
    logic       sample1, latch1, busy1, valid1;
    logic [7:0] dac_p0, dac_n0, result0;
    logic [7:0] dac_p1, dac_n1, result1;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int cnt_s0, cnt_l0, cnt_s1, cnt_l1, run1;
    logic [63:0] cap0;
    logic [7:0]  prev1;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    assign comp0 = (vin0 >= dac_p0);
    assign comp1 = (vin1 >= dac_p1);

    sar_ctrl #(.SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .comp(comp0),
        .sample(sample0), .latch_en(latch0), .dac_p(dac_p0), .dac_n(dac_n0),
        .result(result0), .busy(busy0), .valid(valid0)
    );

    sar_ctrl #(.SAMPLE_CYCLES(3), .SETTLE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .comp(comp1),
        .sample(sample1), .latch_en(latch1), .dac_p(dac_p1), .dac_n(dac_n1),
        .result(result1), .busy(busy1), .valid(valid1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor for the default-timing instance.
    always @(negedge clk) begin
        if (!rst) begin
            cnt_s0 = 0; cnt_l0 = 0; cap0 = 64'd0;
        end else begin
            check("dac_n0", {56'd0, dac_n0}, {56'd0, ~dac_p0});
            if (sample0) cnt_s0++;
            if (latch0) begin
                cnt_l0++;
                cap0 = {cap0[55:0], dac_p0};
            end
            if (valid0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid0 actual=1 required=0");
                end else begin
                    e0 = q0.pop_front();
                    check("result0", result0, e0.res);
                    check("valid_edge0", edge_cnt, e0.due);
                    check("busy_at_valid0", busy0, 1'b0);
                    check("sample_cycles0", cnt_s0, 2);
                    check("latch_count0", cnt_l0, 8);
                    if (e0.chk) check("trials0", cap0, e0.trials);
                end
                cnt_s0 = 0; cnt_l0 = 0; cap0 = 64'd0;
            end
        end
    end

    // Monitor for the 3/2 timing instance.
    always @(negedge clk) begin
        if (!rst) begin
            cnt_s1 = 0; cnt_l1 = 0; run1 = 0; prev1 = 8'h00;
        end else begin
            check("dac_n1", {56'd0, dac_n1}, {56'd0, ~dac_p1});
            if (dac_p1 != prev1) run1 = 1;
            else run1++;
            prev1 = dac_p1;
            if (sample1) cnt_s1++;
            if (latch1) begin
                cnt_l1++;
                check("latch_settle_idx1", run1, 2);
            end
            if (valid1) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid1 actual=1 required=0");
                end else begin
                    e1 = q1.pop_front();
                    check("result1", result1, e1.res);
                    check("valid_edge1", edge_cnt, e1.due);
                    check("sample_cycles1", cnt_s1, 3);
                    check("latch_count1", cnt_l1, 8);
                end
                cnt_s1 = 0; cnt_l1 = 0;
            end
        end
    end

    task automatic conv0(input logic [7:0] v, input logic chk, input logic glitch);
        exp_t e;
        @(negedge clk);
        vin0 = v; start0 = 1'b1;
        e.res = v; e.due = edge_cnt + 1 + 10; e.chk = chk;
        e.trials = 64'h80C0A0B0A8A4A6A5;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        check("busy_after_accept0", busy0, 1'b1);
        if (glitch) begin
            repeat (4) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        repeat (14) @(negedge clk);
    endtask

    task automatic conv1(input logic [7:0] v);
        exp_t e;
        @(negedge clk);
        vin1 = v; start1 = 1'b1;
        e.res = v; e.due = edge_cnt + 1 + 19; e.chk = 1'b0; e.trials = 64'd0;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_sample"}, sample0, 1'b0);
        check({tag, "_latch"}, latch0, 1'b0);
        check({tag, "_dac_p"}, dac_p0, 8'h00);
        check({tag, "_dac_n"}, dac_n0, 8'hFF);
        check({tag, "_result"}, result0, 8'h00);
        check({tag, "_busy"}, busy0, 1'b0);
        check({tag, "_valid"}, valid0, 1'b0);
    endtask

    initial begin
        int base;
        exp_t e;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; vin0 = 8'h00; vin1 = 8'h00;
        repeat (2) @(negedge clk);
        check_reset0("por0");
        check("por1_dac_n", dac_n1, 8'hFF);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        conv0(8'hA5, 1'b1, 1'b0);
        conv0(8'h00, 1'b0, 1'b0);
        conv0(8'hFF, 1'b0, 1'b0);
        conv1(8'hA5);
        conv1(8'h3C);

        // start held high across two conversions
        @(negedge clk);
        vin0 = 8'h33; start0 = 1'b1;
        base = edge_cnt + 1;
        e.res = 8'h33; e.chk = 1'b0; e.trials = 64'd0;
        e.due = base + 10; q0.push_back(e);
        e.due = base + 21; q0.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (edge_cnt >= base + 21) break;
        end
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_held0", busy0, 1'b0);

        conv0(8'h5A, 1'b0, 1'b1);

        // abort during bit 4 of a conversion
        conv0(8'h3C, 1'b0, 1'b0);
        check("result_before_rst", result0, 8'h3C);
        @(negedge clk);
        vin0 = 8'h77; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("bit4_trial", dac_p0, 8'h70);
        #1 rst = 1'b0;
        #1 check_reset0("abort0");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("no_restart_busy", busy0, 1'b0);
        check("no_restart_dac", dac_p0, 8'h00);
        check("no_restart_result", result0, 8'h00);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_CYCLES, default 2, meaning the number of cycles the track switch is held closed (legal range 1..15).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles each trial code is held before its decision (legal range 1..15).
REQ-003 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: conversion request, sampled on the clk rising edge.
REQ-006 Port comp, input, 1 bit: clocked comparator output; 1 means Vin >= DAC trial level.
REQ-007 Port sample, output, 1 bit: high closes the input track switch.
REQ-008 Port latch_en, output, 1 bit: comparator strobe; high during the last settle cycle of each bit.
REQ-009 Port dac_p, output, 8 bits: capacitor-DAC switch code.
REQ-010 Port dac_n, output, 8 bits: always the bitwise complement of dac_p.
REQ-011 Port result, output, 8 bits: last completed conversion; feeds the SPI slave din register.
REQ-012 Port busy, output, 1 bit: high from the cycle after start is accepted until valid rises.
REQ-013 Port valid, output, 1 bit: single-cycle pulse marking result update.

Function
REQ-014 The FSM SHALL have states IDLE, SAMPLE, CONV and DONE.
REQ-015 In IDLE, start=1 at an edge SHALL move the FSM to SAMPLE; start=0 SHALL hold IDLE.
REQ-016 In SAMPLE, the block SHALL drive sample=1 and dac_p=0x00 for exactly SAMPLE_CYCLES cycles, then enter CONV with bit index 7.
REQ-017 In CONV, for bit i = 7 down to 0, dac_p SHALL equal the decided upper bits, with bit i set and lower bits 0, for exactly SETTLE_CYCLES cycles.
REQ-018 latch_en SHALL be 1 only in the last of those settle cycles.
REQ-019 At the edge ending the last settle cycle, bit i SHALL keep its value 1 if comp=1 and SHALL clear if comp=0.
REQ-020 comp SHALL be ignored at all other times.
REQ-021 After the bit-0 decision, result SHALL load the final code, valid SHALL be 1 for one cycle (state DONE) and busy SHALL fall in the same cycle.
REQ-022 valid SHALL rise at exactly the (SAMPLE_CYCLES + 8*SETTLE_CYCLES)-th rising edge after the edge that accepts start; with defaults this is the 10th edge.
REQ-023 DONE SHALL behave like IDLE for start: start=1 in DONE SHALL be accepted and go to SAMPLE, which allows back-to-back conversions.
REQ-024 Otherwise DONE SHALL go to IDLE.
REQ-025 start while in SAMPLE or CONV SHALL be ignored and SHALL NOT restart or extend the conversion.
REQ-026 result SHALL hold its value until the next conversion completes; an aborted conversion SHALL NOT modify result.
REQ-027 In IDLE and DONE, dac_p SHALL be 0x00, and sample and latch_en SHALL be 0.
REQ-028 Every output SHALL be registered; dac_n SHALL be derived from the dac_p register.

Reset
REQ-029 While rst=0, the block SHALL hold: state IDLE, sample=0, latch_en=0, dac_p=0x00, dac_n=0xFF, result=0x00, busy=0, valid=0, and all counters 0.
REQ-030 Reset SHALL take effect asynchronously, including mid-conversion; the interrupted conversion SHALL be discarded.
REQ-031 After rst rises, the block SHALL require a new start.

Structure
REQ-032 Shared package sar_pkg SHALL hold the state enumeration, the code width constant (8) and the counter width constant (4).
REQ-033 One sub-module, sar_timer, SHALL contain a loadable down-counter with a terminal-count flag, reused for both the sample and settle intervals.
REQ-034 The FSM, bit pointer and code register SHALL remain in sar_ctrl.

Verification
REQ-035 Bench comparator model comp = (vin >= dac_p), defaults, vin=0xA5, start pulse: result=0xA5, valid on the 10th edge, dac_p trial sequence 80,C0,A0,B0,A8,A4,A6,A5.
REQ-036 With vin=0x00 the result SHALL be 0x00; with vin=0xFF the result SHALL be 0xFF; dac_n SHALL equal ~dac_p on every cycle.
REQ-037 With SAMPLE_CYCLES=3 and SETTLE_CYCLES=2: sample SHALL be high 3 cycles, latch_en SHALL pulse 8 times, each in the 2nd settle cycle, and valid SHALL rise on the 19th edge.
REQ-038 start held high for an entire conversion: exactly one conversion in progress, a new conversion accepted at DONE, and valid pulses spaced 11 cycles apart (defaults).
REQ-039 Set result=0x3C via a completed conversion, then pulse rst low during bit 4 of the next conversion: all outputs SHALL hit their reset values immediately and result SHALL read 0x00.
REQ-040 start pulse during CONV (vin=0x5A): no restart, result=0x5A, valid on the original schedule.
